stall_cnt_collector: RTL and testbench

Collects the per-operator stall counters of a mono application after a run and streams them out one word per beat. Arms a run by pulsing a counter clear, waits until every operator reports done, snapshots all counters in one cycle, then serializes the snapshot on a valid/ready stream to the host-side logging path. Sits between the array of per-operator stall counters and the readout interface.

---
 rtl/stall_cnt_pkg.sv | 27 ++
 rtl/stall_cnt_collector_snap.sv | 42 ++++
 rtl/stall_cnt_collector.sv | 127 ++++++++++++
 tb/tb_stall_cnt_collector.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/stall_cnt_pkg.sv
// rtl/stall_cnt_pkg.sv - shared state encoding, default widths and saturating add for the stall counter collector
package stall_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } state_t;

    localparam int DEF_CNT_W = 32;
    localparam int SAT_MAX_W = 64;

    // Width-generic: operands are zero-extended, the result is clamped to 2^w-1.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int                   w
    );
        logic [SAT_MAX_W:0] sum;
        logic [SAT_MAX_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
        return (sum > lim) ? lim[SAT_MAX_W-1:0] : sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/stall_cnt_collector_snap.sv
// rtl/stall_cnt_collector_snap.sv - stall_snap_bank: one-cycle capture of all counters plus indexed read mux
module stall_snap_bank
    import stall_cnt_pkg::*;
#(
    parameter int NUM_OPS = 8,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int IDX_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cap_en,
    input  logic [NUM_OPS*CNT_W-1:0] cnt_in,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [CNT_W-1:0]         rd_data
);

    localparam int AW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    logic [CNT_W-1:0] snap_q [NUM_OPS];
    logic [CNT_W-1:0] snap_d [NUM_OPS];

    always_comb begin
        for (int i = 0; i < NUM_OPS; i++) begin
            snap_d[i] = cap_en ? cnt_in[i*CNT_W +: CNT_W] : snap_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_OPS; i++) snap_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OPS; i++) snap_q[i] <= snap_d[i];
        end
    end

    // Indices past the last operator (the total beat) read as zero.
    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < NUM_OPS) rd_data = snap_q[rd_idx[AW-1:0]];
    end

endmodule

// File: rtl/stall_cnt_collector.sv
// rtl/stall_cnt_collector.sv - arms, waits for all operators done, snapshots and streams stall counters
// Optional trailing saturated-total beat: STALL_CNT_COLLECT_TOTAL_EN
module stall_cnt_collector
    import stall_cnt_pkg::*;
#(
    parameter int NUM_OPS = 8,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_OPS-1:0]            op_done,
    input  logic [NUM_OPS*CNT_W-1:0]      cnt_in,
    output logic                          clr_cnt,
    output logic                          busy,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [CNT_W-1:0]              m_data,
    output logic [$clog2(NUM_OPS+1)-1:0]  m_idx,
    output logic                          m_last
);

    localparam int IDX_W = $clog2(NUM_OPS+1);
`ifdef STALL_CNT_COLLECT_TOTAL_EN
    localparam int NUM_BEATS = NUM_OPS + 1;
`else
    localparam int NUM_BEATS = NUM_OPS;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    state_t             state_q, state_d;
    logic [NUM_OPS-1:0] done_mask_q, done_mask_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               snap_en;
    logic [CNT_W-1:0]   rd_data;
`ifdef STALL_CNT_COLLECT_TOTAL_EN
    logic [CNT_W-1:0]   acc_q, acc_d;
`endif

    stall_snap_bank #(
        .NUM_OPS (NUM_OPS),
        .CNT_W   (CNT_W),
        .IDX_W   (IDX_W)
    ) u_snap (
        .clk     (clk),
        .reset   (reset),
        .cap_en  (snap_en),
        .cnt_in  (cnt_in),
        .rd_idx  (idx_q),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            done_mask_q <= '0;
            idx_q       <= '0;
`ifdef STALL_CNT_COLLECT_TOTAL_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            done_mask_q <= done_mask_d;
            idx_q       <= idx_d;
`ifdef STALL_CNT_COLLECT_TOTAL_EN
            acc_q       <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        done_mask_d = done_mask_q;
        idx_d       = idx_q;
        snap_en     = 1'b0;
        clr_cnt     = 1'b0;
        busy        = (state_q != IDLE);
        m_valid     = 1'b0;
        m_data      = '0;
        m_idx       = '0;
        m_last      = 1'b0;
`ifdef STALL_CNT_COLLECT_TOTAL_EN
        acc_d       = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = CLR;
            end
            CLR: begin
                clr_cnt     = 1'b1;
                done_mask_d = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                done_mask_d = done_mask_q | op_done;
                // Decision uses the registered mask, so a dump starts two edges after the final done.
                if (&done_mask_q) begin
                    snap_en = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
`ifdef STALL_CNT_COLLECT_TOTAL_EN
                    acc_d   = '0;
`endif
                end
            end
            SEND: begin
                m_valid = 1'b1;
                m_idx   = idx_q;
                m_last  = (idx_q == LAST_IDX);
                m_data  = rd_data;
`ifdef STALL_CNT_COLLECT_TOTAL_EN
                if (idx_q == IDX_W'(NUM_OPS)) m_data = acc_q;
`endif
                if (m_ready) begin
                    idx_d = idx_q + 1'b1;
`ifdef STALL_CNT_COLLECT_TOTAL_EN
                    if (int'(idx_q) < NUM_OPS)
                        acc_d = CNT_W'(sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(rd_data), CNT_W));
`endif
                    if (idx_q == LAST_IDX) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stall_cnt_collector.sv
// tb/tb_stall_cnt_collector.sv - table-driven bench for stall_cnt_collector (NUM_OPS=4, CNT_W=8)
module tb_stall_cnt_collector;

    localparam int NUM_OPS = 4;
    localparam int CNT_W   = 8;
    localparam int IDX_W   = 3;
`ifdef STALL_CNT_COLLECT_TOTAL_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     start = 1'b0;
    logic [NUM_OPS-1:0]       op_done = '0;
    logic [NUM_OPS*CNT_W-1:0] cnt_in = '0;
    logic                     m_ready = 1'b0;
    logic                     clr_cnt, busy, m_valid, m_last;
    logic [CNT_W-1:0]         m_data;
    logic [IDX_W-1:0]         m_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] c [4];
        bit         tog;
        logic [7:0] tot;
    } vec_t;

    vec_t vecs [5];

    stall_cnt_collector #(.NUM_OPS(NUM_OPS), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op_done (op_done),
        .cnt_in  (cnt_in),
        .clr_cnt (clr_cnt),
        .busy    (busy),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_idx   (m_idx),
        .m_last  (m_last)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input vec_t v, input logic [7:0] add);
        return {v.c[3] + add, v.c[2] + add, v.c[1] + add, v.c[0] + add};
    endfunction

    // start in IDLE, clr pulse, all done in first WAIT cycle, m_valid two cycles later.
    task automatic arm(input vec_t v);
        start = 1'b1;
        step();
        chk("clr_pulse", 32'(clr_cnt), 32'd1);
        start = 1'b0;
        step();
        chk("clr_one_cycle", 32'(clr_cnt), 32'd0);
        cnt_in  = pack(v, 8'd0);
        op_done = 4'hF;
        step();
        chk("no_early_valid", 32'(m_valid), 32'd0);
        op_done = 4'h0;
        step();
        chk("valid_latency", 32'(m_valid), 32'd1);
        cnt_in = pack(v, 8'd100);
    endtask

    task automatic collect(input vec_t v);
        logic [7:0] exp [5];
        int beat = 0;
        int cyc  = 0;
        bit ph   = 1'b1;
        for (int i = 0; i < 4; i++) exp[i] = v.c[i];
        exp[4] = v.tot;
        while (beat < NB && cyc < 40) begin
            m_ready = v.tog ? ph : 1'b1;
            ph = ~ph;
            chk("m_valid", 32'(m_valid), 32'd1);
            chk("m_idx", 32'(m_idx), 32'(beat));
            chk("m_data", 32'(m_data), 32'(exp[beat]));
            chk("m_last", 32'(m_last), 32'(beat == NB-1));
            if (m_valid && m_ready) beat++;
            step();
            cyc++;
        end
        if (beat < NB) chk("dump_timeout", 32'(beat), 32'(NB));
        m_ready = 1'b0;
        chk("busy_after_dump", 32'(busy), 32'd0);
        chk("valid_after_dump", 32'(m_valid), 32'd0);
    endtask

    initial begin
        vecs[0].c = '{8'd10,  8'd20,  8'd30, 8'd40}; vecs[0].tog = 1'b0; vecs[0].tot = 8'd100;
        vecs[1].c = '{8'd1,   8'd2,   8'd3,  8'd4};  vecs[1].tog = 1'b1; vecs[1].tot = 8'd10;
        vecs[2].c = '{8'd1,   8'd5,   8'd100, 8'd200}; vecs[2].tog = 1'b0; vecs[2].tot = 8'd255;
        vecs[3].c = '{8'd255, 8'd0,   8'd0,  8'd0};  vecs[3].tog = 1'b1; vecs[3].tot = 8'd255;
        vecs[4].c = '{8'd100, 8'd100, 8'd50, 8'd6};  vecs[4].tog = 1'b1; vecs[4].tot = 8'd255;

        #1;
        chk("rst_clr_cnt", 32'(clr_cnt), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data",  32'(m_data),  32'd0);
        chk("rst_m_idx",   32'(m_idx),   32'd0);
        chk("rst_m_last",  32'(m_last),  32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 5; v++) begin
            arm(vecs[v]);
            collect(vecs[v]);
        end

        // Done seen during CLR is dropped; staggered pulses with start held high (ignored).
        start = 1'b1;
        step();
        chk("stag_clr", 32'(clr_cnt), 32'd1);
        op_done = 4'hF;
        step();
        chk("stag_clr_once", 32'(clr_cnt), 32'd0);
        cnt_in  = pack(vecs[1], 8'd0);
        op_done = 4'h1;
        step();
        op_done = 4'h0;
        for (int i = 0; i < 4; i++) begin
            chk("clr_done_ignored", 32'(m_valid), 32'd0);
            chk("start_rearm", 32'(clr_cnt), 32'd0);
            step();
        end
        op_done = 4'h6;
        step();
        op_done = 4'h0;
        for (int i = 0; i < 3; i++) begin
            chk("stag_no_valid", 32'(m_valid), 32'd0);
            step();
        end
        op_done = 4'h8;
        step();
        op_done = 4'h0;
        chk("stag_w1", 32'(m_valid), 32'd0);
        step();
        chk("stag_w2", 32'(m_valid), 32'd1);
        start  = 1'b0;
        cnt_in = pack(vecs[1], 8'd100);
        collect(vecs[1]);

        // Reset in the middle of a dump.
        arm(vecs[0]);
        m_ready = 1'b1;
        step();
        step();
        chk("mid_idx", 32'(m_idx), 32'd2);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_busy",  32'(busy),    32'd0);
        chk("mid_rst_idx",   32'(m_idx),   32'd0);
        chk("mid_rst_data",  32'(m_data),  32'd0);
        chk("mid_rst_last",  32'(m_last),  32'd0);
        m_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("post_rst_idle", 32'(busy), 32'd0);
        arm(vecs[0]);
        collect(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
